// File: rtl/lisnoc_dma_request_store_if.sv
// Configuration/initiator bundle for the DMA request table.
interface lisnoc_dma_request_store_if #(
  parameter int unsigned rtile_width = 5
);
  localparam int unsigned ReqWidth = 97 + rtile_width;

  // Software side: field writes, valid writes, status reads
  logic [ReqWidth-1:0] if_write_req;
  logic [1:0]          if_write_pos;
  logic [4:0]          if_write_select;
  logic                if_write_en;
  logic [1:0]          if_valid_pos;
  logic                if_valid_set;
  logic                if_valid_en;
  logic                if_validrd_en;
  logic [3:0]          done;

  // Initiator side: offer handshake and completions
  logic [ReqWidth-1:0] ctrl_req;
  logic [1:0]          ctrl_req_pos;
  logic                ctrl_req_valid;
  logic                ctrl_req_ack;
  logic [1:0]          ctrl_done_pos;
  logic                ctrl_done_en;
  logic                irq;

  modport slave (
    input  if_write_req, if_write_pos, if_write_select, if_write_en,
    input  if_valid_pos, if_valid_set, if_valid_en, if_validrd_en,
    output done,
    output ctrl_req, ctrl_req_pos, ctrl_req_valid,
    input  ctrl_req_ack, ctrl_done_pos, ctrl_done_en,
    output irq
  );

  modport master (
    output if_write_req, if_write_pos, if_write_select, if_write_en,
    output if_valid_pos, if_valid_set, if_valid_en, if_validrd_en,
    input  done,
    input  ctrl_req, ctrl_req_pos, ctrl_req_valid,
    output ctrl_req_ack, ctrl_done_pos, ctrl_done_en,
    input  irq
  );
endinterface

// File: rtl/lisnoc_dma_request_store.sv
// DMA request table: four descriptor slots, per-entry valid/busy/done tracking and a
// round-robin offer to the DMA initiator. Descriptor layout {laddr,size,rtile,raddr,dir}.
module lisnoc_dma_request_store #(
  parameter int unsigned rtile_width = 5
) (
  input logic                        clk,
  input logic                        rst,
  lisnoc_dma_request_store_if.slave  bus
);
  localparam int unsigned ReqWidth = 97 + rtile_width;
  localparam int unsigned Entries  = 4;

  logic [Entries-1:0][31:0]            laddr_q, laddr_d;
  logic [Entries-1:0][31:0]            size_q, size_d;
  logic [Entries-1:0][rtile_width-1:0] rtile_q, rtile_d;
  logic [Entries-1:0][31:0]            raddr_q, raddr_d;
  logic [Entries-1:0]                  dir_q, dir_d;

  logic [Entries-1:0] valid_q, valid_d;
  logic [Entries-1:0] busy_q, busy_d;
  logic [Entries-1:0] done_q, done_d;
  logic [1:0]         rr_q, rr_d;

  logic [ReqWidth-1:0] req_q, req_d;
  logic [1:0]          req_pos_q, req_pos_d;
  logic                req_valid_q, req_valid_d;
  logic                irq_q, irq_d;

  logic [Entries-1:0][ReqWidth-1:0] desc;
  logic [Entries-1:0]               eligible;
  logic                             found;
  logic [1:0]                       pick;

  // Descriptor fields; a valid entry is locked against field writes
  always_comb begin
    laddr_d = laddr_q;
    size_d  = size_q;
    rtile_d = rtile_q;
    raddr_d = raddr_q;
    dir_d   = dir_q;
    if (bus.if_write_en && !valid_q[bus.if_write_pos]) begin
      if (bus.if_write_select[0]) laddr_d[bus.if_write_pos] = bus.if_write_req[ReqWidth-1 -: 32];
      if (bus.if_write_select[1]) size_d[bus.if_write_pos]  = bus.if_write_req[ReqWidth-33 -: 32];
      if (bus.if_write_select[2]) rtile_d[bus.if_write_pos] = bus.if_write_req[33 +: rtile_width];
      if (bus.if_write_select[3]) raddr_d[bus.if_write_pos] = bus.if_write_req[1 +: 32];
      if (bus.if_write_select[4]) dir_d[bus.if_write_pos]   = bus.if_write_req[0];
    end
  end

  // Round-robin search for the first eligible entry starting at rr_q
  always_comb begin
    eligible = valid_q & ~busy_q & ~done_q;
    found    = 1'b0;
    pick     = rr_q;
    for (int i = 0; i < Entries; i++) begin
      if (!found && eligible[rr_q + 2'(i)]) begin
        found = 1'b1;
        pick  = rr_q + 2'(i);
      end
    end
  end

  // Packed descriptor view per entry, used when registering an offer
  always_comb begin
    for (int e = 0; e < Entries; e++) begin
      desc[e] = {laddr_q[e], size_q[e], rtile_q[e], raddr_q[e], dir_q[e]};
    end
  end

  // Entry status, offer handshake and completion interrupt
  always_comb begin
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rr_d        = rr_q;
    req_d       = req_q;
    req_pos_d   = req_pos_q;
    req_valid_d = req_valid_q;
    irq_d       = 1'b0;

    if (bus.if_valid_en) begin
      if (bus.if_valid_set) begin
        if (!valid_q[bus.if_valid_pos]) begin
          valid_d[bus.if_valid_pos] = 1'b1;
          done_d[bus.if_valid_pos]  = 1'b0;
        end
      end else if (!busy_q[bus.if_valid_pos]) begin
        // Busy entries are owned by the initiator and cannot be aborted
        valid_d[bus.if_valid_pos] = 1'b0;
      end
    end

    // Reading a completed entry frees it
    if (bus.if_validrd_en && done_q[bus.if_valid_pos]) begin
      done_d[bus.if_valid_pos]  = 1'b0;
      valid_d[bus.if_valid_pos] = 1'b0;
    end

    if (bus.ctrl_done_en && busy_q[bus.ctrl_done_pos]) begin
      done_d[bus.ctrl_done_pos] = 1'b1;
      busy_d[bus.ctrl_done_pos] = 1'b0;
      irq_d                     = 1'b1;
    end

    if (req_valid_q) begin
      if (bus.ctrl_req_ack) begin
        busy_d[req_pos_q] = 1'b1;
        req_valid_d       = 1'b0;
        rr_d              = req_pos_q + 2'd1;
      end
    end else if (found) begin
      req_d       = desc[pick];
      req_pos_d   = pick;
      req_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laddr_q     <= '0;
      size_q      <= '0;
      rtile_q     <= '0;
      raddr_q     <= '0;
      dir_q       <= '0;
      valid_q     <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      rr_q        <= '0;
      req_q       <= '0;
      req_pos_q   <= '0;
      req_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      laddr_q     <= laddr_d;
      size_q      <= size_d;
      rtile_q     <= rtile_d;
      raddr_q     <= raddr_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      req_q       <= req_d;
      req_pos_q   <= req_pos_d;
      req_valid_q <= req_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.done           = done_q;
  assign bus.ctrl_req       = req_q;
  assign bus.ctrl_req_pos   = req_pos_q;
  assign bus.ctrl_req_valid = req_valid_q;
  assign bus.irq            = irq_q;

endmodule
